// File: rtl/vc_credit_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// vc_credit_scheduler_pkg
// Shared router constants used by the VC credit scheduler:
//   - lock FSM state encoding
//   - flow-control (credit return) field layout: {valid, vc index}
//   - helpers that derive widths/credit counts from the VC parameters
// No ports (package).
// ---------------------------------------------------------------------------
package vc_credit_scheduler_pkg;

   // Packet-lock FSM states.
   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_e;

   // Value of the flow_ctrl valid bit that marks a credit return.
   localparam logic FC_CREDIT = 1'b1;

   // Width of the VC index field inside flow_ctrl (num_vcs >= 2).
   function automatic int fc_idx_width(input int n_vcs);
      return $clog2(n_vcs);
   endfunction

   // Bit position of the valid flag: it sits directly above the index field.
   function automatic int fc_valid_pos(input int n_vcs);
      return fc_idx_width(n_vcs);
   endfunction

   // Total flow_ctrl width: {valid, index}.
   function automatic int fc_width(input int n_vcs);
      return 1 + fc_idx_width(n_vcs);
   endfunction

   // Downstream buffer slots owned by each VC.
   function automatic int credits_per_vc(input int buf_size, input int n_vcs);
      return buf_size / n_vcs;
   endfunction

endpackage

// File: rtl/vc_credit_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// vcs_rr_arbiter
// Round-robin arbiter. Grant is combinational from req; the search starts at
// the requester after the last one granted. The pointer moves only when the
// owner signals that the grant was actually used (update).
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (VC 0 gets top priority)
//   req      in   [N-1:0] requests
//   update   in   grant consumed this cycle, advance pointer
//   gnt      out  [N-1:0] zero or one-hot grant
// ---------------------------------------------------------------------------
module vcs_rr_arbiter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         update,
   output logic [N-1:0] gnt
);

   localparam int IW = $clog2(N);

   // Index of the last granted requester; reset to N-1 so that the search
   // after reset starts at requester 0.
   logic [IW-1:0] last_q;
   logic [IW-1:0] last_d;
   logic          found;
   logic [IW-1:0] pick;
   logic [IW-1:0] j_idx;
   int            j;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      pick  = last_q;
      j     = 0;
      j_idx = '0;
      for (int i = 0; i < N; i++) begin
         // Walk last+1, last+2, ... with wrap; works for any N, not only 2^k.
         j = int'(last_q) + 1 + i;
         if (j >= N) begin
            j = j - N;
         end
         j_idx = IW'(j);
         if (!found && req[j_idx]) begin
            found = 1'b1;
            pick  = j_idx;
         end
      end
      if (found) begin
         gnt[pick] = 1'b1;
      end
   end

   always_comb begin
      last_d = last_q;
      if (update && found) begin
         last_d = pick;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= IW'(N - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/vc_credit_scheduler.sv
// ---------------------------------------------------------------------------
// vc_credit_scheduler
// Credit-based scheduler for num_vcs virtual channels sharing one output
// channel. Each VC owns buffer_size/num_vcs downstream slots tracked by a
// credit counter; a VC may send only while it holds credit. Arbitration is
// round-robin; with packet_lock=1 a VC keeps the channel from head to tail.
// Ports:
//   clk                in   clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   active             in   scheduler enable (credits accepted when 0)
//   req_ivc            in   [num_vcs-1:0] per-VC flit ready
//   req_tail_ivc       in   [num_vcs-1:0] per-VC ready flit is a tail
//   flow_ctrl          in   credit return {valid, vc index}
//   gnt_valid          out  a flit is sent this cycle
//   gnt_ivc            out  [num_vcs-1:0] one-hot granted VC
//   credits_avail_ivc  out  [num_vcs-1:0] per-VC counter nonzero
//   error              out  sticky credit overflow / underflow / bad index
// ---------------------------------------------------------------------------
module vc_credit_scheduler
   import vc_credit_scheduler_pkg::*;
#(
   parameter int num_vcs     = 8,
   parameter int buffer_size = 64,
   parameter int packet_lock = 0
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               active,
   input  logic [num_vcs-1:0]                 req_ivc,
   input  logic [num_vcs-1:0]                 req_tail_ivc,
   input  logic [fc_width(num_vcs)-1:0]       flow_ctrl,
   output logic                               gnt_valid,
   output logic [num_vcs-1:0]                 gnt_ivc,
   output logic [num_vcs-1:0]                 credits_avail_ivc,
   output logic                               error
);

   localparam int              IW       = fc_idx_width(num_vcs);
   localparam int              CPV      = credits_per_vc(buffer_size, num_vcs);
   localparam int              CW       = $clog2(CPV + 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(CPV);
   localparam logic [IW:0]     FC_LIMIT = (IW + 1)'(num_vcs);

   // ---------------------------------------------------------------- decode
   logic          fc_valid;
   logic [IW-1:0] fc_idx;
   logic          fc_idx_ok;

   assign fc_valid  = (flow_ctrl[fc_valid_pos(num_vcs)] == FC_CREDIT);
   assign fc_idx    = flow_ctrl[IW-1:0];
   assign fc_idx_ok = ({1'b0, fc_idx} < FC_LIMIT);

   // ---------------------------------------------------------------- state
   lock_state_e   state_q;
   lock_state_e   state_d;
   logic [IW-1:0] locked_vc_q;
   logic [IW-1:0] locked_vc_d;
   logic          error_q;
   logic          error_d;

   logic [num_vcs-1:0] ret_vec;
   logic [num_vcs-1:0] elig;
   logic [num_vcs-1:0] ovf_vec;
   logic [num_vcs-1:0] unf_vec;

   // ---------------------------------------------------------------- per VC
   for (genvar gi = 0; gi < num_vcs; gi++) begin : g_vc
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          ovf;
      logic          unf;
      logic          lock_ok;

      assign ret_vec[gi]           = fc_valid && fc_idx_ok && (fc_idx == IW'(gi));
      assign credits_avail_ivc[gi] = (cnt_q != '0);
      // While locked only the owning VC may compete.
      assign lock_ok  = (state_q == ST_UNLOCKED) || (locked_vc_q == IW'(gi));
      // reset_n gates the request so no grant appears while reset is held.
      assign elig[gi] = reset_n && active && req_ivc[gi] && credits_avail_ivc[gi] && lock_ok;

      // A grant and a return in the same cycle cancel out.
      always_comb begin
         cnt_d = cnt_q;
         ovf   = 1'b0;
         unf   = 1'b0;
         if (ret_vec[gi] && !gnt_ivc[gi]) begin
            if (cnt_q == CNT_FULL) begin
               ovf = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else if (gnt_ivc[gi] && !ret_vec[gi]) begin
            if (cnt_q == '0) begin
               unf = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      end

      assign ovf_vec[gi] = ovf;
      assign unf_vec[gi] = unf;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= CNT_FULL;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   // ---------------------------------------------------------------- arbiter
   vcs_rr_arbiter #(
      .N (num_vcs)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (elig),
      .update  (gnt_valid),
      .gnt     (gnt_ivc)
   );

   assign gnt_valid = |gnt_ivc;

   // ---------------------------------------------------------------- lock FSM
   logic [IW-1:0] gnt_idx;
   logic          gnt_tail;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < num_vcs; i++) begin
         if (gnt_ivc[i]) begin
            gnt_idx = IW'(i);
         end
      end
   end

   assign gnt_tail = |(gnt_ivc & req_tail_ivc);

   always_comb begin
      state_d     = state_q;
      locked_vc_d = locked_vc_q;
      case (state_q)
         ST_UNLOCKED: begin
            // A granted non-tail flit is a packet head (or body): hold the channel.
            if ((packet_lock != 0) && gnt_valid && !gnt_tail) begin
               state_d     = ST_LOCKED;
               locked_vc_d = gnt_idx;
            end
         end
         ST_LOCKED: begin
            // Only locked_vc can be granted here, so any granted tail ends the packet.
            if (gnt_valid && gnt_tail) begin
               state_d = ST_UNLOCKED;
            end
         end
         default: begin
            state_d = ST_UNLOCKED;
         end
      endcase
   end

   // ---------------------------------------------------------------- error
   always_comb begin
      error_d = error_q | (|ovf_vec) | (|unf_vec) | (fc_valid && !fc_idx_ok);
   end

   assign error = error_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_UNLOCKED;
         locked_vc_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         locked_vc_q <= locked_vc_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_vc_credit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vc_credit_scheduler
// Scoreboard bench for vc_credit_scheduler (4 VCs, 16-flit buffer, packet
// lock enabled). The driver applies one cycle of stimulus, asks a behavioural
// model for that cycle's expected outputs and queues them; the monitor pops
// one entry per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_vc_credit_scheduler;

   localparam int NV  = 4;
   localparam int BS  = 16;
   localparam int CPV = BS / NV;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       active;
   logic [3:0] req_ivc;
   logic [3:0] req_tail_ivc;
   logic [2:0] flow_ctrl;
   logic       gnt_valid;
   logic [3:0] gnt_ivc;
   logic [3:0] credits_avail_ivc;
   logic       error;

   always #5 clk = ~clk;

   vc_credit_scheduler #(
      .num_vcs     (NV),
      .buffer_size (BS),
      .packet_lock (1)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .active            (active),
      .req_ivc           (req_ivc),
      .req_tail_ivc      (req_tail_ivc),
      .flow_ctrl         (flow_ctrl),
      .gnt_valid         (gnt_valid),
      .gnt_ivc           (gnt_ivc),
      .credits_avail_ivc (credits_avail_ivc),
      .error             (error)
   );

   typedef struct {
      logic [3:0] gnt;
      logic [3:0] avail;
      logic       err;
      int         cyc;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // ------------------------------------------------ behavioural model
   // Credits as integers, a "next VC to try first" index, a lock flag.
   int m_cred[NV];
   int m_next;
   bit m_locked;
   int m_lock_vc;
   bit m_err;

   task automatic m_reset();
      for (int v = 0; v < NV; v++) m_cred[v] = CPV;
      m_next    = 0;
      m_locked  = 1'b0;
      m_lock_vc = 0;
      m_err     = 1'b0;
   endtask

   // fc_mode: 0 = no return, 1 = return to fc_idx, 2 = return to granted VC.
   task automatic step(input bit rst, input bit act, input logic [3:0] rq,
                       input logic [3:0] tl, input int fc_mode, input int fc_idx,
                       input string tag);
      int   g;
      int   v;
      bit   fv;
      int   fi;
      exp_t e;
      reset_n      = !rst;
      active       = act;
      req_ivc      = rq;
      req_tail_ivc = tl;
      if (rst) m_reset();
      g = -1;
      if (!rst && act) begin
         for (int k = 0; k < NV; k++) begin
            v = (m_next + k) % NV;
            if (g < 0 && rq[v] && m_cred[v] > 0 && (!m_locked || v == m_lock_vc)) g = v;
         end
      end
      fv = 1'b0;
      fi = 0;
      if (!rst && fc_mode == 1) begin
         fv = 1'b1;
         fi = fc_idx;
      end else if (!rst && fc_mode == 2 && g >= 0) begin
         fv = 1'b1;
         fi = g;
      end
      flow_ctrl = {fv, 2'(fi)};
      e.gnt = (g >= 0) ? 4'(1 << g) : 4'b0000;
      for (int i = 0; i < NV; i++) e.avail[i] = (m_cred[i] > 0);
      e.err = m_err;
      e.cyc = cyc;
      e.tag = tag;
      exp_q.push_back(e);
      // State seen after the next rising edge.
      if (!rst) begin
         if (fv && fi != g) begin
            if (m_cred[fi] == CPV) m_err = 1'b1;
            else m_cred[fi] = m_cred[fi] + 1;
         end
         if (g >= 0) begin
            if (!(fv && fi == g)) m_cred[g] = m_cred[g] - 1;
            m_next = (g + 1) % NV;
            if (!m_locked && !tl[g]) begin
               m_locked  = 1'b1;
               m_lock_vc = g;
            end else if (m_locked && tl[g]) begin
               m_locked = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // ------------------------------------------------ monitor
   task automatic chk(input string name, input int c, input logic [31:0] act_v,
                      input logic [31:0] exp_v);
      total++;
      if (act_v !== exp_v) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act_v, exp_v);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("txn cyc=%0d %s gnt=%b avail=%b err=%b", e.cyc, e.tag,
                     gnt_ivc, credits_avail_ivc, error);
            chk({e.tag, ".gnt_ivc"},   e.cyc, 32'(gnt_ivc),           32'(e.gnt));
            chk({e.tag, ".gnt_valid"}, e.cyc, 32'(gnt_valid),         32'(|e.gnt));
            chk({e.tag, ".avail"},     e.cyc, 32'(credits_avail_ivc), 32'(e.avail));
            chk({e.tag, ".error"},     e.cyc, 32'(error),             32'(e.err));
         end
      end
   end

   // ------------------------------------------------ driver
   initial begin
      int r;
      int mode;
      reset_n      = 1'b0;
      active       = 1'b0;
      req_ivc      = '0;
      req_tail_ivc = '0;
      flow_ctrl    = '0;
      m_reset();
      @(posedge clk);
      #1;

      // Reset with requests present: no grant, full credits.
      repeat (2) step(1, 1, 4'hF, 4'hF, 0, 0, "reset");

      // Single VC exhausts its 4 credits.
      repeat (6) step(0, 1, 4'b0001, 4'hF, 0, 0, "drain_vc0");
      repeat (4) step(0, 1, 4'b0000, 4'hF, 1, 0, "refill_vc0");

      // All request, credit returned for each granted VC: 0,1,2,3,0.
      step(1, 1, 4'h0, 4'hF, 0, 0, "reset");
      repeat (5) step(0, 1, 4'hF, 4'hF, 2, 0, "rr_return");

      // Drain VC2, then unblock it with a credit; simultaneous grant+return on VC1.
      repeat (4) step(0, 1, 4'b0100, 4'hF, 0, 0, "drain_vc2");
      step(0, 1, 4'b0110, 4'hF, 1, 2, "ret_vc2");
      step(0, 1, 4'b0110, 4'hF, 0, 0, "vc2_after_ret");
      step(0, 1, 4'b0010, 4'hF, 1, 1, "vc1_gnt_and_ret");
      repeat (4) step(0, 1, 4'b0010, 4'hF, 0, 0, "vc1_count");

      // Disabled scheduler still takes credits.
      repeat (3) step(0, 0, 4'hF, 4'hF, 1, 2, "inactive");

      // Overflow on full VC3 is sticky until reset.
      step(1, 1, 4'h0, 4'hF, 0, 0, "reset");
      step(0, 1, 4'h0, 4'hF, 1, 3, "ovf_vc3");
      repeat (3) step(0, 1, 4'hF, 4'hF, 2, 0, "err_sticky");
      step(1, 1, 4'h0, 4'hF, 0, 0, "reset_clr_err");

      // Packet lock on VC1 until its tail, then VC2 next.
      step(0, 1, 4'b0010, 4'h0, 0, 0, "lock_head_vc1");
      repeat (4) step(0, 1, 4'hF, 4'h0, 2, 0, "locked_body");
      step(0, 1, 4'hF, 4'b0010, 2, 0, "lock_tail_vc1");
      repeat (3) step(0, 1, 4'hF, 4'hF, 2, 0, "after_unlock");

      // Asynchronous reset while locked on VC0 with one credit left.
      step(1, 1, 4'h0, 4'hF, 0, 0, "reset");
      repeat (3) step(0, 1, 4'b0001, 4'h0, 0, 0, "lock_vc0");
      step(1, 1, 4'hF, 4'h0, 0, 0, "async_reset");
      step(0, 1, 4'b1110, 4'hF, 0, 0, "lock_abandoned");
      repeat (5) step(0, 1, 4'b0001, 4'hF, 0, 0, "vc0_full_again");

      // Randomized traffic.
      step(1, 1, 4'h0, 4'hF, 0, 0, "reset");
      repeat (400) begin
         r    = $urandom_range(0, 9);
         mode = (r < 4) ? 2 : ((r < 6) ? 1 : 0);
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
              4'($urandom), 4'($urandom), mode, $urandom_range(0, NV - 1), "rand");
      end

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vc_credit_scheduler.md
VC_CREDIT_SCHEDULER -- requirements
Module: vc_credit_scheduler

Interface
REQ-001 SHALL have parameter num_vcs, default 8: number of VCs sharing one output channel.
REQ-002 SHALL have parameter buffer_size, default 64: downstream flit buffer size in flits; credits per VC = buffer_size/num_vcs.
REQ-003 SHALL have parameter packet_lock, default 0: 1 = hold the channel for one VC from head to tail; 0 = flit-level interleaving.
REQ-004 SHALL have ports, one per line:
  clk  input  1  sole clock, rising edge.
  reset_n  input  1  asynchronous, active-low reset.
  active  input  1  scheduler enable; 0 forces no grant, credits still accepted.
  req_ivc  input  num_vcs  per-VC flit ready.
  req_tail_ivc  input  num_vcs  per-VC ready flit is a tail.
  flow_ctrl  input  1+clog2(num_vcs)  credit return {valid, vc index}.
  gnt_valid  output  1  a flit is sent this cycle.
  gnt_ivc  output  num_vcs  one-hot granted VC.
  credits_avail_ivc  output  num_vcs  per-VC credit count nonzero.
  error  output  1  sticky credit overflow or underflow.

Function
REQ-005 SHALL keep one credit counter per VC, width clog2(credits_per_vc+1), range 0..credits_per_vc.
REQ-006 SHALL treat VC v as eligible when req_ivc[v]=1, counter[v]>0 and active=1.
REQ-007 SHALL compute gnt_ivc combinationally in the same cycle: round-robin among eligible VCs, starting at the VC after the last granted VC.
REQ-008 SHALL assert gnt_valid iff gnt_ivc is nonzero; gnt_ivc SHALL be zero or one-hot.
REQ-009 SHALL advance the round-robin pointer only on cycles with gnt_valid=1.
REQ-010 SHALL, on a grant to VC v without a credit return for v, decrement counter[v] at the next edge.
REQ-011 SHALL, on a credit return (flow_ctrl valid, index v) without a grant to v, increment counter[v] at the next edge.
REQ-012 SHALL leave counter[v] unchanged when a grant and a credit return for v occur in the same cycle.
REQ-013 SHALL, on a credit return to a counter already at credits_per_vc, hold the counter saturated and set error.
REQ-014 SHALL ignore a flow_ctrl index >= num_vcs and set error.
REQ-015 SHALL, with packet_lock=1, run an FSM with states UNLOCKED and LOCKED, plus a locked_vc register.
REQ-016 UNLOCKED->LOCKED SHALL occur when a non-tail flit is granted; locked_vc takes the granted VC.
REQ-017 In LOCKED, only locked_vc SHALL be eligible; the other VCs see no grant even if eligible.
REQ-018 LOCKED->UNLOCKED SHALL occur when a tail flit is granted to locked_vc.
REQ-019 SHALL, with packet_lock=0, keep the FSM in UNLOCKED permanently.
REQ-020 SHALL keep error set until reset once it is set.

Reset
REQ-021 On reset_n=0, each counter SHALL be set to credits_per_vc.
REQ-022 On reset_n=0, the round-robin pointer SHALL be set so that VC 0 has highest priority, the FSM SHALL enter UNLOCKED, and error SHALL be set to 0.
REQ-023 During reset, outputs SHALL be gnt_valid=0, gnt_ivc=0, credits_avail_ivc=all ones.
REQ-024 Reset asserted mid-packet SHALL abandon the lock; no credit state is retained.

Structure
REQ-025 Flow-control type constants and the flow_ctrl field layout SHALL come from the shared router constants package.
REQ-026 The round-robin arbiter SHALL be one sub-module, vcs_rr_arbiter (req, update, gnt); counters and FSM stay in the top level.

Verification (num_vcs=4, buffer_size=16, 4 credits/VC)
REQ-027 req_ivc=0001 held for 6 cycles, no credit returns -> exactly 4 grants to VC0, then credits_avail_ivc[0]=0 and gnt_valid=0.
REQ-028 req_ivc=1111, credit returned every cycle for each granted VC -> grant order 0,1,2,3,0, with counters unchanged.
REQ-029 counter[2]=0, grant-blocked VC2 receives a credit -> VC2 is granted the next cycle; a simultaneous grant and return on VC1 leaves counter[1] unchanged.
REQ-030 Credit returned to VC3 at 4/4 -> error=1, counter stays 4, error persists until reset_n falls.
REQ-031 packet_lock=1: VC1 head granted, req_ivc=1111 -> only VC1 is granted until its tail, then arbitration resumes at VC2.
REQ-032 reset_n pulsed low while LOCKED with counter[0]=1 -> FSM UNLOCKED and all counters = 4 immediately (asynchronously).
